// File: rtl/cmos_pwr_seq.sv
// Power-gating sequencer for a switch-level CMOS island.
// Drives header gate, isolation clamp and island reset against pwr_req.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   pwr_req         : level request, 1 = island should be powered
//   pwr_good        : island rail-good sense (synchronous)
//   hdr_gate        : pmos header gate, 0 = conducting
//   iso             : isolation clamp, 1 = outputs clamped
//   rst_isl         : island reset, active high
//   pwr_ack         : island powered, out of reset, unclamped
//   busy            : in RAMP, RELRST, ISO or DOWN
//   err             : sticky power-up timeout flag
module cmos_pwr_seq #(
  parameter int unsigned WAKE_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TMO_CYCLES    = 16,
  parameter int unsigned CW            = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pwr_req,
  input  logic pwr_good,
  output logic hdr_gate,
  output logic iso,
  output logic rst_isl,
  output logic pwr_ack,
  output logic busy,
  output logic err
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_RAMP   = 3'd1,
    S_RELRST = 3'd2,
    S_ON     = 3'd3,
    S_ISO    = 3'd4,
    S_DOWN   = 3'd5
  } state_t;

  localparam logic [CW-1:0] WAKE_M1   = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_M1    = CW'(TMO_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          hdr_gate_q, hdr_gate_d;
  logic          iso_q, iso_d;
  logic          rst_isl_q, rst_isl_d;
  logic          pwr_ack_q, pwr_ack_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      S_OFF: begin
        if (pwr_req) begin
          state_d = S_RAMP;
          err_d   = 1'b0;
        end
      end
      S_RAMP: begin
        // Abort beats good, good beats timeout.
        if (!pwr_req) begin
          state_d = S_DOWN;
        end else if (cnt_q >= WAKE_M1 && pwr_good) begin
          state_d = S_RELRST;
        end else if (cnt_q == TMO_M1) begin
          state_d = S_DOWN;
          err_d   = 1'b1;
        end
      end
      S_RELRST: begin
        if (!pwr_req) begin
          state_d = S_DOWN;
        end else if (cnt_q == SETTLE_M1) begin
          state_d = S_ON;
        end
      end
      S_ON: begin
        if (!pwr_req) begin
          state_d = S_ISO;
        end
      end
      S_ISO: begin
        state_d = S_DOWN;
      end
      S_DOWN: begin
        if (cnt_q == SETTLE_M1) begin
          state_d = S_OFF;
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs are decoded from the next state so the registered
  // copies line up with state_q.
  always_comb begin
    hdr_gate_d = 1'b1;
    iso_d      = 1'b1;
    rst_isl_d  = 1'b1;
    pwr_ack_d  = 1'b0;
    busy_d     = 1'b0;
    unique case (state_d)
      S_OFF: begin
      end
      S_RAMP: begin
        hdr_gate_d = 1'b0;
        busy_d     = 1'b1;
      end
      S_RELRST: begin
        hdr_gate_d = 1'b0;
        rst_isl_d  = 1'b0;
        busy_d     = 1'b1;
      end
      S_ON: begin
        hdr_gate_d = 1'b0;
        iso_d      = 1'b0;
        rst_isl_d  = 1'b0;
        pwr_ack_d  = 1'b1;
      end
      S_ISO: begin
        hdr_gate_d = 1'b0;
        rst_isl_d  = 1'b0;
        busy_d     = 1'b1;
      end
      S_DOWN: begin
        busy_d     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      hdr_gate_q <= 1'b1;
      iso_q      <= 1'b1;
      rst_isl_q  <= 1'b1;
      pwr_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      hdr_gate_q <= hdr_gate_d;
      iso_q      <= iso_d;
      rst_isl_q  <= rst_isl_d;
      pwr_ack_q  <= pwr_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign hdr_gate = hdr_gate_q;
  assign iso      = iso_q;
  assign rst_isl  = rst_isl_q;
  assign pwr_ack  = pwr_ack_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule
